// File: rtl/lc3_pkg.sv
// Shared LC-3 datapath constants: widths and NZP condition-code encodings.
// Imported by the register file, its interface and the NZP classifier.
package lc3_pkg;

  localparam int DATA_W     = 16;
  localparam int REG_CNT    = 8;
  localparam int REG_ADDR_W = 3;

  typedef logic [2:0] nzp_t;

  localparam nzp_t CC_N      = 3'b100;
  localparam nzp_t CC_Z      = 3'b010;
  localparam nzp_t CC_P      = 3'b001;
  localparam nzp_t NZP_RESET = CC_Z;

endpackage

// File: rtl/regfile_cc_if.sv
// Datapath-side bundle for the register file: write-back bus, register selects,
// CC/BEN load strobes and the read/flag results.
interface regfile_cc_if #(
  parameter int DATA_W = lc3_pkg::DATA_W
);
  import lc3_pkg::*;

  logic [DATA_W-1:0]     busIn;
  logic [REG_ADDR_W-1:0] dr;
  logic                  ldReg;
  logic [REG_ADDR_W-1:0] sr1;
  logic [REG_ADDR_W-1:0] sr2;
  logic                  ldCC;
  logic [2:0]            irNzp;
  logic                  ldBen;
  logic [DATA_W-1:0]     Ra;
  logic [DATA_W-1:0]     Rb;
  nzp_t                  nzp;
  logic                  ben;

  modport master (
    output busIn, dr, ldReg, sr1, sr2, ldCC, irNzp, ldBen,
    input  Ra, Rb, nzp, ben
  );

  modport slave (
    input  busIn, dr, ldReg, sr1, sr2, ldCC, irNzp, ldBen,
    output Ra, Rb, nzp, ben
  );

endinterface

// File: rtl/nzp_gen.sv
// Sign/zero classifier: maps a datapath word to a one-hot {N,Z,P} code.
// Purely combinational so other datapath blocks can reuse it.
module nzp_gen #(
  parameter int DATA_W = lc3_pkg::DATA_W
) (
  input  logic [DATA_W-1:0] i_value,
  output logic [2:0]        o_nzp
);
  import lc3_pkg::*;

  always_comb begin
    o_nzp = CC_P;
    if (i_value[DATA_W-1]) begin
      o_nzp = CC_N;
    end else if (i_value == '0) begin
      o_nzp = CC_Z;
    end
  end

endmodule

// File: rtl/regfile_cc.sv
// LC-3 general register file with NZP condition codes and branch-enable flag.
// Flop-based array: async active-low reset, combinational reads, no write bypass.
module regfile_cc #(
  parameter int DATA_W  = lc3_pkg::DATA_W,
  parameter int REG_CNT = lc3_pkg::REG_CNT
) (
  input  logic          clk,
  input  logic          resetN,
  regfile_cc_if.slave   bus
);
  import lc3_pkg::*;

  logic [DATA_W-1:0] r_regs [REG_CNT];
  nzp_t              r_nzp;
  logic              r_ben;
  nzp_t              w_nzpNext;

  // CC comes from the write-back bus itself, so it is valid even when ldReg=0.
  nzp_gen #(.DATA_W(DATA_W)) u_nzpGen (
    .i_value (bus.busIn),
    .o_nzp   (w_nzpNext)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < REG_CNT; i++) begin
        r_regs[i] <= '0;
      end
    end else if (bus.ldReg) begin
      r_regs[bus.dr] <= bus.busIn;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_nzp <= NZP_RESET;
    end else if (bus.ldCC) begin
      r_nzp <= w_nzpNext;
    end
  end

  // Uses the pre-edge r_nzp, so a same-cycle ldCC does not affect this decision.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_ben <= 1'b0;
    end else if (bus.ldBen) begin
      r_ben <= |(bus.irNzp & r_nzp);
    end
  end

  assign bus.Ra  = r_regs[bus.sr1];
  assign bus.Rb  = r_regs[bus.sr2];
  assign bus.nzp = r_nzp;
  assign bus.ben = r_ben;

endmodule

// File: tb/tb_regfile_cc.sv
// Self-checking bench for regfile_cc: vector table through a scoreboard queue,
// plus hand sequences for same-cycle reads and asynchronous reset.
module tb_regfile_cc;
  import lc3_pkg::*;

  typedef struct {
    string       name;
    logic        ldReg;
    logic [2:0]  dr;
    logic [15:0] busIn;
    logic [2:0]  sr1;
    logic [2:0]  sr2;
    logic        ldCC;
    logic        ldBen;
    logic [2:0]  irNzp;
    logic [15:0] expRa;
    logic [15:0] expRb;
    logic [2:0]  expNzp;
    logic        expBen;
  } vecT;

  typedef struct {
    string       name;
    logic [15:0] ra;
    logic [15:0] rb;
    logic [2:0]  nzp;
    logic        ben;
  } expT;

  logic clk;
  logic resetN;

  regfile_cc_if #(.DATA_W(16)) bus ();

  regfile_cc #(.DATA_W(16), .REG_CNT(8)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  expT         scoreboard [$];
  vecT         vecs [13];
  logic [15:0] modelRegs [8];
  int          vecCount  = 0;
  int          missCount = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vecT mkVec(input string name, input logic ldReg, input logic [2:0] dr,
                                input logic [15:0] busIn, input logic [2:0] sr1,
                                input logic [2:0] sr2, input logic ldCC, input logic ldBen,
                                input logic [2:0] irNzp, input logic [15:0] expRa,
                                input logic [15:0] expRb, input logic [2:0] expNzp,
                                input logic expBen);
    vecT v;
    v.name   = name;   v.ldReg = ldReg;   v.dr    = dr;    v.busIn  = busIn;
    v.sr1    = sr1;    v.sr2   = sr2;     v.ldCC  = ldCC;  v.ldBen  = ldBen;
    v.irNzp  = irNzp;  v.expRa = expRa;   v.expRb = expRb; v.expNzp = expNzp;
    v.expBen = expBen;
    return v;
  endfunction

  task automatic checkField(input string name, input logic [15:0] act, input logic [15:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, wanted %h", name, act, exp);
    end
  endtask

  task automatic idleInputs();
    bus.busIn = '0; bus.dr = '0; bus.ldReg = 1'b0; bus.sr1 = '0; bus.sr2 = '0;
    bus.ldCC = 1'b0; bus.irNzp = '0; bus.ldBen = 1'b0;
  endtask

  // Drives one vector at the falling edge and queues the outputs it must produce after the next rising edge.
  task automatic applyStimulus(input vecT v);
    expT e;
    @(negedge clk);
    bus.ldReg = v.ldReg; bus.dr = v.dr; bus.busIn = v.busIn; bus.sr1 = v.sr1; bus.sr2 = v.sr2;
    bus.ldCC = v.ldCC; bus.ldBen = v.ldBen; bus.irNzp = v.irNzp;
    e.name = v.name; e.ra = v.expRa; e.rb = v.expRb; e.nzp = v.expNzp; e.ben = v.expBen;
    scoreboard.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput();
    expT e;
    if (scoreboard.size() == 0) begin
      vecCount++;
      missCount++;
      $display("[TB] FAIL scoreboard_empty: got 0 entries, wanted 1");
      return;
    end
    e = scoreboard.pop_front();
    checkField($sformatf("%s.Ra", e.name),  bus.Ra,  e.ra);
    checkField($sformatf("%s.Rb", e.name),  bus.Rb,  e.rb);
    checkField($sformatf("%s.nzp", e.name), 16'(bus.nzp), 16'(e.nzp));
    checkField($sformatf("%s.ben", e.name), 16'(bus.ben), 16'(e.ben));
  endtask

  initial begin
    #200000;
    missCount++;
    $display("[TB] FAIL watchdog: got timeout, wanted completion");
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // State entering the table: r3=1234, all others 0, nzp=010, ben=0.
    vecs[0]  = mkVec("cc_neg",      0, 0, 16'h8000, 3, 0, 1, 0, 3'b000, 16'h1234, 16'h0000, 3'b100, 0);
    vecs[1]  = mkVec("cc_zero",     0, 0, 16'h0000, 3, 0, 1, 0, 3'b000, 16'h1234, 16'h0000, 3'b010, 0);
    vecs[2]  = mkVec("cc_pos",      0, 0, 16'h7FFF, 3, 0, 1, 0, 3'b000, 16'h1234, 16'h0000, 3'b001, 0);
    vecs[3]  = mkVec("ben_old_p",   0, 0, 16'hFFFF, 3, 3, 1, 1, 3'b001, 16'h1234, 16'h1234, 3'b100, 1);
    vecs[4]  = mkVec("ben_p_clear", 0, 0, 16'h0000, 3, 3, 0, 1, 3'b001, 16'h1234, 16'h1234, 3'b100, 0);
    vecs[5]  = mkVec("ben_n_set",   0, 0, 16'h0000, 3, 3, 0, 1, 3'b100, 16'h1234, 16'h1234, 3'b100, 1);
    vecs[6]  = mkVec("hold",        0, 3, 16'hABCD, 3, 3, 0, 0, 3'b000, 16'h1234, 16'h1234, 3'b100, 1);
    vecs[7]  = mkVec("wr_no_cc",    1, 0, 16'h5555, 0, 3, 0, 0, 3'b000, 16'h5555, 16'h1234, 3'b100, 1);
    vecs[8]  = mkVec("wr_and_cc",   1, 1, 16'h8001, 1, 0, 1, 0, 3'b000, 16'h8001, 16'h5555, 3'b100, 1);
    vecs[9]  = mkVec("ben_zp_miss", 0, 0, 16'h0000, 1, 1, 0, 1, 3'b011, 16'h8001, 16'h8001, 3'b100, 0);
    vecs[10] = mkVec("cc_from_bus", 0, 1, 16'h0001, 1, 0, 1, 0, 3'b000, 16'h8001, 16'h5555, 3'b001, 0);
    vecs[11] = mkVec("ben_ir_none", 0, 0, 16'h0000, 1, 0, 0, 1, 3'b000, 16'h8001, 16'h5555, 3'b001, 0);
    vecs[12] = mkVec("ben_zp_hit",  0, 0, 16'h0000, 1, 0, 0, 1, 3'b011, 16'h8001, 16'h5555, 3'b001, 1);

    resetN = 1'b0;
    idleInputs();
    #2;
    for (int i = 0; i < 8; i++) begin
      bus.sr1 = 3'(i);
      bus.sr2 = 3'(7 - i);
      #1;
      checkField("rst_hold_Ra", bus.Ra, 16'h0000);
      checkField("rst_hold_Rb", bus.Rb, 16'h0000);
    end
    checkField("rst_hold_nzp", 16'(bus.nzp), 16'(CC_Z));
    checkField("rst_hold_ben", 16'(bus.ben), 16'h0000);

    @(negedge clk);
    resetN = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.sr1 = 3'(i);
      bus.sr2 = 3'(i);
      #1;
      checkField("rst_rel_Ra", bus.Ra, 16'h0000);
      checkField("rst_rel_Rb", bus.Rb, 16'h0000);
    end
    checkField("rst_rel_nzp", 16'(bus.nzp), 16'(CC_Z));
    checkField("rst_rel_ben", 16'(bus.ben), 16'h0000);

    // Same-cycle read of the destination must still see the old value.
    @(negedge clk);
    bus.dr = 3'd3; bus.busIn = 16'h1234; bus.ldReg = 1'b1; bus.sr1 = 3'd3; bus.sr2 = 3'd0;
    #1;
    checkField("wr_same_cycle_Ra", bus.Ra, 16'h0000);
    @(posedge clk);
    #1;
    checkField("wr_next_cycle_Ra", bus.Ra, 16'h1234);
    @(negedge clk);
    bus.ldReg = 1'b0; bus.sr2 = 3'd3;
    #1;
    checkField("same_idx_Ra", bus.Ra, 16'h1234);
    checkField("same_idx_Rb", bus.Rb, 16'h1234);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput();
    end

    // Asynchronous reset dropped between edges while a write is pending.
    applyStimulus(mkVec("wr_r7", 1, 7, 16'hBEEF, 7, 0, 0, 0, 3'b000, 16'hBEEF, 16'h5555, 3'b001, 1));
    checkOutput();
    @(negedge clk);
    bus.ldReg = 1'b1; bus.dr = 3'd7; bus.busIn = 16'h1111; bus.sr1 = 3'd7; bus.sr2 = 3'd0;
    #2;
    resetN = 1'b0;
    #1;
    checkField("async_rst_Ra", bus.Ra, 16'h0000);
    checkField("async_rst_Rb", bus.Rb, 16'h0000);
    checkField("async_rst_nzp", 16'(bus.nzp), 16'(CC_Z));
    checkField("async_rst_ben", 16'(bus.ben), 16'h0000);
    @(posedge clk);
    #1;
    checkField("rst_wins_Ra", bus.Ra, 16'h0000);
    @(negedge clk);
    resetN = 1'b1;
    bus.ldReg = 1'b0;
    #1;
    checkField("rst_after_Ra", bus.Ra, 16'h0000);

    for (int i = 0; i < 8; i++) begin
      modelRegs[i] = 16'hC0DE ^ 16'(i * 16'h1111);
      applyStimulus(mkVec("sweep_wr", 1, 3'(i), modelRegs[i], 3'(i), 3'(i), 0, 0, 3'b000,
                          modelRegs[i], modelRegs[i], CC_Z, 0));
      checkOutput();
    end
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        applyStimulus(mkVec($sformatf("sweep_rd_%0d_%0d", i, j), 0, 0, 16'h0000, 3'(i), 3'(j),
                            0, 0, 3'b000, modelRegs[i], modelRegs[j], CC_Z, 0));
        checkOutput();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/regfile_cc.md
REGFILE_CC -- requirements
Module: regfile_cc

Interface
REQ-001 Parameter: DATA_W, default 16, datapath width in bits.
REQ-002 Parameter: REG_CNT, default 8, number of general registers; address width is log2(REG_CNT) = 3.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 resetN  input  1  reset, asynchronous and active-low.
REQ-005 busIn  input  DATA_W  write-back value (ALU result, memory data or PC) from the datapath bus.
REQ-006 dr  input  3  destination register index.
REQ-007 ldReg  input  1  write enable for register dr.
REQ-008 sr1  input  3  read port A index.
REQ-009 sr2  input  3  read port B index.
REQ-010 ldCC  input  1  load enable for the NZP condition codes.
REQ-011 irNzp  input  3  branch condition field IR[11:9] as {n,z,p}.
REQ-012 ldBen  input  1  load enable for the branch-enable flag.
REQ-013 Ra  output  DATA_W  contents of register sr1; drives ALU operand A.
REQ-014 Rb  output  DATA_W  contents of register sr2; drives ALU operand B.
REQ-015 nzp  output  3  registered condition codes {N,Z,P}.
REQ-016 ben  output  1  registered branch-enable flag.

Function
REQ-017 Ra and Rb shall be combinational reads of the register array, with no output register.
REQ-018 A write shall occur on the rising clk edge when ldReg=1: reg[dr] <= busIn.
REQ-019 There shall be no write-to-read bypass: a read of dr in the write cycle shall return the old value, and the new value shall appear after the edge.
REQ-020 sr1 = sr2 shall be legal; both outputs shall then carry the same value.
REQ-021 The CC update on a rising edge with ldCC=1 shall follow this rule:
- busIn[DATA_W-1]=1 -> nzp=100.
- busIn=0 -> nzp=010.
- otherwise -> nzp=001.
REQ-022 nzp shall always be one-hot once reset has been released.
REQ-023 CC shall be derived from busIn, not from the register array.
REQ-024 ldCC shall operate independently of ldReg; ldCC=1 with ldReg=0 shall still update nzp.
REQ-025 On a rising edge with ldBen=1, ben <= (irNzp[2]&N) | (irNzp[1]&Z) | (irNzp[0]&P), using the nzp value held before that edge.
REQ-026 When ldCC and ldBen are asserted in the same cycle, ben shall use the old nzp, and nzp shall take its new value at the same edge.
REQ-027 When ldReg, ldCC and ldBen are all low, all state shall hold.
REQ-028 Write latency shall be 1 cycle. Read latency shall be 0 cycles (combinational).

Reset
REQ-029 While resetN=0, asynchronously:
- all REG_CNT registers shall be 0.
- nzp shall be 010.
- ben shall be 0.
REQ-030 Reset asserted mid-write shall win: the register shall be 0 after reset regardless of ldReg.
REQ-031 Ra and Rb shall read 0 during reset.
REQ-032 Release of reset shall be synchronised externally, and the first state update shall occur at the first rising edge with resetN=1.

Structure
REQ-033 A shared package (lc3_pkg) shall hold:
- DATA_W and REG_CNT.
- REG_ADDR_W = 3.
- NZP encodings CC_N = 100, CC_Z = 010, CC_P = 001.
- The NZP reset value.
REQ-034 The sign/zero classifier shall be one combinational sub-module, nzp_gen (busIn -> 3-bit one-hot). It shall be reusable by other datapath blocks.
REQ-035 The register array shall be flip-flops, not inferred RAM, so that asynchronous reset and combinational read are supported.

Verification
REQ-036 Reset check: hold resetN=0, then release -> all registers read 0 on both ports, nzp=010, ben=0.
REQ-037 Write/read check:
- Stimulus: write dr=3, busIn=0x1234, ldReg=1; in the same cycle sr1=3.
- Required: Ra=0x0000 in that cycle and Ra=0x1234 in the next cycle.
- Then sr1=sr2=3 -> Ra=Rb=0x1234.
REQ-038 CC check with ldCC=1, ldReg=0, busIn stepped through 0x8000, 0x0000, 0x7FFF:
- nzp = 100, then 010, then 001.
- Every register shall be unchanged.
REQ-039 BEN check:
- Stimulus: nzp=001 held; in one cycle ldCC=1 with busIn=0xFFFF, ldBen=1, irNzp=001.
- Required: ben=1 (old P) and nzp=100.
- Next cycle, ldBen=1, irNzp=001 -> ben=0.
REQ-040 Async reset mid-operation:
- Stimulus: write 0xBEEF to register 7; drop resetN between clock edges while ldReg=1.
- Required: register 7 reads 0 immediately, without waiting for a clock edge; nzp=010.
REQ-041 Sweep: write a unique value to every register 0-7, then read all pairs on sr1/sr2 -> every read returns the value written to that index.
